// File: rtl/vend_pkg.sv
// Shared encodings for the vending controller: coin and change codes,
// denomination values, FSM states and the coin-to-value lookup.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_VEND,
      S_CHANGE
   } state_t;

   localparam logic [2:0] COIN_1  = 3'd0;
   localparam logic [2:0] COIN_2  = 3'd1;
   localparam logic [2:0] COIN_5  = 3'd2;
   localparam logic [2:0] COIN_10 = 3'd3;
   localparam logic [2:0] COIN_20 = 3'd4;

   localparam logic [2:0] CHG_NONE = 3'd0;
   localparam logic [2:0] CHG_10   = 3'd1;
   localparam logic [2:0] CHG_20   = 3'd2;
   localparam logic [2:0] CHG_2    = 3'd3;
   localparam logic [2:0] CHG_5    = 3'd4;
   localparam logic [2:0] CHG_1    = 3'd5;

   localparam logic [4:0] VAL_1  = 5'd1;
   localparam logic [4:0] VAL_2  = 5'd2;
   localparam logic [4:0] VAL_5  = 5'd5;
   localparam logic [4:0] VAL_10 = 5'd10;
   localparam logic [4:0] VAL_20 = 5'd20;

   // Codes 5-7 map to zero; callers treat them as invalid separately.
   function automatic logic [4:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_1:  return VAL_1;
         COIN_2:  return VAL_2;
         COIN_5:  return VAL_5;
         COIN_10: return VAL_10;
         COIN_20: return VAL_20;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters. Vends decrement, restocks increment with saturation;
// a vend and a restock of the same item in one cycle cancel out.
module vend_stock_bank #(
   parameter int NUM_ITEMS  = 10,
   parameter int STOCK_W    = 3,
   parameter int INIT_STOCK = 2
)(
   input  logic                         CLK,
   input  logic                         reset_n,
   input  logic                         dec_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0] dec_id,
   input  logic                         inc_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0] inc_id,
   output logic [NUM_ITEMS-1:0]         empty
);

   localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

   logic [STOCK_W-1:0]   stock [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] dec_hot;
   logic [NUM_ITEMS-1:0] inc_hot;

   assign dec_hot = dec_valid ? (NUM_ITEMS'(1) << dec_id) : '0;
   assign inc_hot = inc_valid ? (NUM_ITEMS'(1) << inc_id) : '0;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            stock[i] <= STOCK_W'(INIT_STOCK);
         end
      end else begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            if (inc_hot[i] && !dec_hot[i] && stock[i] != STOCK_MAX) begin
               stock[i] <= stock[i] + 1'b1;
            end else if (dec_hot[i] && !inc_hot[i] && stock[i] != '0) begin
               stock[i] <= stock[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         empty[i] = (stock[i] == '0);
      end
   end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending money controller: coin/card credit, per-item price and
// stock checks, session vend limit, greedy change return and idle timeout.
module vend_ctrl_multi
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS       = 10,
   parameter int BAL_W           = 8,
   parameter int STOCK_W         = 3,
   parameter int INIT_STOCK      = 2,
   // Item 0 is the rightmost slice: prices 50,25,10,30,25,20,10,7,20,5.
   parameter logic [NUM_ITEMS*BAL_W-1:0] PRICES =
      {8'd5, 8'd20, 8'd7, 8'd10, 8'd20, 8'd25, 8'd30, 8'd10, 8'd25, 8'd50},
   parameter int MAX_TRANSACTION = 3,
   parameter int TIMEOUT_CYC     = 1000
)(
   input  logic                         CLK,
   input  logic                         reset_n,
   input  logic                         coin_valid,
   input  logic [2:0]                   coin_sel,
   input  logic                         card_present,
   input  logic                         sel_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0] sel_id,
   input  logic                         rr,
   input  logic                         restock_valid,
   input  logic [$clog2(NUM_ITEMS)-1:0] restock_id,
   output logic [BAL_W-1:0]             balance,
   output logic                         vend_valid,
   output logic [$clog2(NUM_ITEMS)-1:0] vend_id,
   output logic [NUM_ITEMS-1:0]         sold_out,
   output logic                         insuf,
   output logic                         limit,
   output logic                         coin_reject,
   output logic                         change_valid,
   output logic [2:0]                   change_code,
   output logic                         busy
);

   localparam int TXN_W = $clog2(MAX_TRANSACTION + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_t               state;
   logic [TXN_W-1:0]     txn;
   logic [TMO_W-1:0]     tmo;
   logic [BAL_W-1:0]     price_tbl [NUM_ITEMS];
   logic [NUM_ITEMS-1:0] stock_zero;
   logic [NUM_ITEMS-1:0] mark_hot;
   logic [NUM_ITEMS-1:0] clear_hot;
   logic [BAL_W:0]       coin_sum;
   logic [BAL_W-1:0]     sel_price;
   logic [BAL_W-1:0]     chg_val;
   logic [2:0]           chg_code;
   logic in_entry, rr_act, coin_take, sel_card, sel_live, sel_empty;
   logic sel_go, sel_poor, sel_mark;

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
      assign price_tbl[i] = PRICES[i*BAL_W +: BAL_W];
   end

   // Input arbitration: rr beats coin, and any coin strobe drops a selection.
   always_comb begin
      in_entry  = (state == S_IDLE) || (state == S_ACCUM);
      rr_act    = in_entry && rr && (balance != '0);
      coin_sum  = {1'b0, balance} + (BAL_W+1)'(coin_value(coin_sel));
      coin_take = coin_valid && !rr_act && in_entry && !card_present &&
                  (coin_sel <= COIN_20) && !coin_sum[BAL_W];
      sel_card  = card_present && in_entry;
      sel_live  = sel_valid && !rr_act && !coin_valid && !limit &&
                  (sel_card || state == S_ACCUM) && (int'(sel_id) < NUM_ITEMS);
      sel_price = '0;
      sel_empty = 1'b0;
      if (int'(sel_id) < NUM_ITEMS) begin
         sel_price = price_tbl[sel_id];
         sel_empty = stock_zero[sel_id];
      end
      sel_go   = sel_live && !sel_empty && (sel_card || balance >= sel_price);
      sel_poor = sel_live && !sel_empty && !sel_card && (balance < sel_price);
      sel_mark = sel_live && sel_empty;
   end

   always_comb begin
      chg_code = CHG_NONE;
      chg_val  = '0;
      if (balance >= BAL_W'(VAL_20)) begin
         chg_code = CHG_20;
         chg_val  = BAL_W'(VAL_20);
      end else if (balance >= BAL_W'(VAL_10)) begin
         chg_code = CHG_10;
         chg_val  = BAL_W'(VAL_10);
      end else if (balance >= BAL_W'(VAL_5)) begin
         chg_code = CHG_5;
         chg_val  = BAL_W'(VAL_5);
      end else if (balance >= BAL_W'(VAL_2)) begin
         chg_code = CHG_2;
         chg_val  = BAL_W'(VAL_2);
      end else if (balance >= BAL_W'(VAL_1)) begin
         chg_code = CHG_1;
         chg_val  = BAL_W'(VAL_1);
      end
   end

   vend_stock_bank #(
      .NUM_ITEMS  (NUM_ITEMS),
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) u_stock (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .dec_valid (sel_go),
      .dec_id    (sel_id),
      .inc_valid (restock_valid),
      .inc_id    (restock_id),
      .empty     (stock_zero)
   );

   assign mark_hot  = sel_mark ? (NUM_ITEMS'(1) << sel_id) : '0;
   assign clear_hot = restock_valid ? (NUM_ITEMS'(1) << restock_id) : '0;

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sold_out <= '0;
      end else begin
         sold_out <= (sold_out | mark_hot) & ~clear_hot;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         balance      <= '0;
         vend_valid   <= 1'b0;
         vend_id      <= '0;
         insuf        <= 1'b0;
         limit        <= 1'b0;
         coin_reject  <= 1'b0;
         change_valid <= 1'b0;
         change_code  <= CHG_NONE;
         busy         <= 1'b0;
         txn          <= TXN_W'(MAX_TRANSACTION);
         tmo          <= '0;
      end else begin
         vend_valid   <= 1'b0;
         insuf        <= 1'b0;
         change_valid <= 1'b0;
         change_code  <= CHG_NONE;
         coin_reject  <= coin_valid && !coin_take;
         case (state)
            S_IDLE, S_ACCUM: begin
               if (rr_act) begin
                  state <= S_CHANGE;
                  busy  <= 1'b1;
                  tmo   <= '0;
               end else if (coin_take) begin
                  balance <= coin_sum[BAL_W-1:0];
                  state   <= S_ACCUM;
                  tmo     <= '0;
               end else if (sel_go) begin
                  state      <= S_VEND;
                  vend_valid <= 1'b1;
                  vend_id    <= sel_id;
                  if (!sel_card) begin
                     balance <= balance - sel_price;
                  end
                  txn <= txn - 1'b1;
                  if (txn == TXN_W'(1)) begin
                     limit <= 1'b1;
                  end
                  tmo <= '0;
               end else if (sel_live) begin
                  insuf <= sel_poor;
                  tmo   <= '0;
               end else if (state == S_ACCUM) begin
                  if (tmo == TMO_LAST) begin
                     state <= S_CHANGE;
                     busy  <= 1'b1;
                     tmo   <= '0;
                  end else begin
                     tmo <= tmo + 1'b1;
                  end
               end
            end
            S_VEND: begin
               state <= (balance != '0) ? S_ACCUM : S_IDLE;
            end
            // Session ends once change is fully paid out.
            S_CHANGE: begin
               if (balance != '0) begin
                  change_valid <= 1'b1;
                  change_code  <= chg_code;
                  balance      <= balance - chg_val;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  txn   <= TXN_W'(MAX_TRANSACTION);
                  limit <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
